// File: rtl/trap_ctrl_if.sv
// Signal bundle between trap_ctrl and its surroundings: commit stage, CLINT, CSR file, fetch.
// The master side drives the trap inputs. The slave side is the sequencer.
interface trap_ctrl_if;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [31:0] exc_pc;
  logic [31:0] exc_tval;
  logic        mret_req;
  logic        pipe_empty;
  logic [31:0] next_pc;
  logic        timer_irq;
  logic        mstatus_mie;
  logic        mie_mtie;
  logic [1:0]  priv_mode;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        trap_enter;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic [31:0] trap_val;
  logic        mret_exec;
  logic        stall_req;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  state_dbg;

  modport master (
    output exc_valid, exc_cause, exc_pc, exc_tval, mret_req, pipe_empty, next_pc,
           timer_irq, mstatus_mie, mie_mtie, priv_mode, mtvec, mepc,
    input  trap_enter, trap_cause, trap_pc, trap_val, mret_exec, stall_req, flush,
           redirect_valid, redirect_pc, state_dbg
  );

  modport slave (
    input  exc_valid, exc_cause, exc_pc, exc_tval, mret_req, pipe_empty, next_pc,
           timer_irq, mstatus_mie, mie_mtie, priv_mode, mtvec, mepc,
    output trap_enter, trap_cause, trap_pc, trap_val, mret_exec, stall_req, flush,
           redirect_valid, redirect_pc, state_dbg
  );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap/mret sequencer: arbitrates exceptions, mret and the timer interrupt,
// drains the pipeline for interrupts and issues registered one-cycle strobes to the CSR file.
module trap_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] MTI_CAUSE   = 32'h8000_0007
) (
  input logic        clk,
  input logic        rst_n,
  trap_ctrl_if.slave io_bus
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StDrain   = 2'd1,
    StAct     = 2'd2,
    StRecover = 2'd3
  } state_e;

  state_e                 r_state, w_state_d;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_irq_ok;
  logic                   w_take_exc, w_take_mret, w_take_irq;

  logic        r_trap_enter, w_trap_enter_d;
  logic        r_mret_exec, w_mret_exec_d;
  logic        r_stall, w_stall_d;
  logic        r_flush, w_flush_d;
  logic        r_redir_valid, w_redir_valid_d;
  logic [31:0] r_cause, w_cause_d;
  logic [31:0] r_tpc, w_tpc_d;
  logic [31:0] r_tval, w_tval_d;
  logic [31:0] r_redir_pc, w_redir_pc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], io_bus.timer_irq};
    end
  end

  // User mode always takes an enabled interrupt regardless of MIE.
  assign w_irq_ok = r_sync[SYNC_STAGES-1] & io_bus.mie_mtie &
                    (io_bus.mstatus_mie | (io_bus.priv_mode == 2'b00));

  always_comb begin
    w_state_d       = r_state;
    w_take_exc      = 1'b0;
    w_take_mret     = 1'b0;
    w_take_irq      = 1'b0;
    w_trap_enter_d  = 1'b0;
    w_mret_exec_d   = 1'b0;
    w_stall_d       = 1'b0;
    w_flush_d       = 1'b0;
    w_redir_valid_d = 1'b0;
    w_cause_d       = r_cause;
    w_tpc_d         = r_tpc;
    w_tval_d        = r_tval;
    w_redir_pc_d    = r_redir_pc;

    unique case (r_state)
      StIdle: begin
        if (io_bus.exc_valid) begin
          w_take_exc = 1'b1;
        end else if (io_bus.mret_req) begin
          w_take_mret = 1'b1;
        end else if (w_irq_ok) begin
          w_state_d = StDrain;
          w_stall_d = 1'b1;
        end
      end
      StDrain: begin
        w_stall_d = 1'b1;
        if (io_bus.exc_valid) begin
          w_take_exc = 1'b1;
        end else if (io_bus.mret_req) begin
          w_take_mret = 1'b1;
        end else if (!w_irq_ok) begin
          w_state_d = StIdle;
          w_stall_d = 1'b0;
        end else if (io_bus.pipe_empty) begin
          w_take_irq = 1'b1;
        end
      end
      StAct:     w_state_d = StRecover;
      StRecover: w_state_d = StIdle;
    endcase

    if (w_take_exc || w_take_mret || w_take_irq) begin
      w_state_d       = StAct;
      w_stall_d       = 1'b1;
      w_flush_d       = 1'b1;
      w_redir_valid_d = 1'b1;
    end
    if (w_take_exc) begin
      w_trap_enter_d = 1'b1;
      w_cause_d      = {28'b0, io_bus.exc_cause};
      w_tpc_d        = io_bus.exc_pc;
      w_tval_d       = io_bus.exc_tval;
      w_redir_pc_d   = io_bus.mtvec;
    end
    if (w_take_mret) begin
      w_mret_exec_d = 1'b1;
      w_redir_pc_d  = io_bus.mepc;
    end
    if (w_take_irq) begin
      w_trap_enter_d = 1'b1;
      w_cause_d      = MTI_CAUSE;
      w_tpc_d        = io_bus.next_pc;
      w_tval_d       = 32'b0;
      w_redir_pc_d   = io_bus.mtvec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_trap_enter  <= 1'b0;
      r_mret_exec   <= 1'b0;
      r_stall       <= 1'b0;
      r_flush       <= 1'b0;
      r_redir_valid <= 1'b0;
      r_cause       <= '0;
      r_tpc         <= '0;
      r_tval        <= '0;
      r_redir_pc    <= '0;
    end else begin
      r_state       <= w_state_d;
      r_trap_enter  <= w_trap_enter_d;
      r_mret_exec   <= w_mret_exec_d;
      r_stall       <= w_stall_d;
      r_flush       <= w_flush_d;
      r_redir_valid <= w_redir_valid_d;
      r_cause       <= w_cause_d;
      r_tpc         <= w_tpc_d;
      r_tval        <= w_tval_d;
      r_redir_pc    <= w_redir_pc_d;
    end
  end

  assign io_bus.trap_enter     = r_trap_enter;
  assign io_bus.mret_exec      = r_mret_exec;
  assign io_bus.stall_req      = r_stall;
  assign io_bus.flush          = r_flush;
  assign io_bus.redirect_valid = r_redir_valid;
  assign io_bus.trap_cause     = r_cause;
  assign io_bus.trap_pc        = r_tpc;
  assign io_bus.trap_val       = r_tval;
  assign io_bus.redirect_pc    = r_redir_pc;
  assign io_bus.state_dbg      = r_state;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: directed stimulus queues expected strobes,
// a negedge monitor pops and compares them whenever trap_enter or mret_exec fires.
module tb_trap_ctrl;

  logic clk;
  logic rst_n;
  trap_ctrl_if bus ();

  trap_ctrl #(
    .SYNC_STAGES(2),
    .MTI_CAUSE  (32'h8000_0007)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_mret;
    logic [31:0] cause;
    logic [31:0] pc;
    logic [31:0] val;
    logic [31:0] rpc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_trap(input logic [31:0] cause, pc, val, rpc);
    exp_t e;
    e.is_mret = 1'b0; e.cause = cause; e.pc = pc; e.val = val; e.rpc = rpc;
    exp_q.push_back(e);
  endtask

  task automatic push_mret(input logic [31:0] rpc);
    exp_t e;
    e.is_mret = 1'b1; e.cause = '0; e.pc = '0; e.val = '0; e.rpc = rpc;
    exp_q.push_back(e);
  endtask

  // Monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && (bus.trap_enter || bus.mret_exec)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_strobe: trap_enter=%b mret_exec=%b, want none",
                 bus.trap_enter, bus.mret_exec);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("strobe_trap_enter", {31'b0, bus.trap_enter}, {31'b0, ~e.is_mret});
        chk("strobe_mret_exec", {31'b0, bus.mret_exec}, {31'b0, e.is_mret});
        chk("strobe_flush", {31'b0, bus.flush}, 32'd1);
        chk("strobe_redirect_valid", {31'b0, bus.redirect_valid}, 32'd1);
        chk("strobe_stall", {31'b0, bus.stall_req}, 32'd1);
        chk("strobe_redirect_pc", bus.redirect_pc, e.rpc);
        if (!e.is_mret) begin
          chk("trap_cause", bus.trap_cause, e.cause);
          chk("trap_pc", bus.trap_pc, e.pc);
          chk("trap_val", bus.trap_val, e.val);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.exc_valid = 1'b0; bus.exc_cause = '0; bus.exc_pc = '0; bus.exc_tval = '0;
    bus.mret_req = 1'b0; bus.pipe_empty = 1'b0; bus.next_pc = '0; bus.timer_irq = 1'b0;
    bus.mstatus_mie = 1'b0; bus.mie_mtie = 1'b0; bus.priv_mode = 2'b11;
    bus.mtvec = 32'h100; bus.mepc = '0;

    // Reset state
    tick(2);
    chk("rst_state", {30'b0, bus.state_dbg}, 32'd0);
    chk("rst_trap_enter", {31'b0, bus.trap_enter}, 32'd0);
    chk("rst_stall", {31'b0, bus.stall_req}, 32'd0);
    chk("rst_redirect_pc", bus.redirect_pc, 32'd0);
    chk("rst_trap_cause", bus.trap_cause, 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Synchronous exception
    bus.exc_valid = 1'b1; bus.exc_cause = 4'd2; bus.exc_pc = 32'h80; bus.exc_tval = 32'hDEAD;
    push_trap(32'h2, 32'h80, 32'hDEAD, 32'h100);
    tick(1);
    bus.exc_valid = 1'b0;
    chk("exc_act_state", {30'b0, bus.state_dbg}, 32'd2);
    tick(1);
    chk("exc_recover_state", {30'b0, bus.state_dbg}, 32'd3);
    chk("exc_recover_flush", {31'b0, bus.flush}, 32'd0);
    tick(1);
    chk("exc_idle_state", {30'b0, bus.state_dbg}, 32'd0);
    chk("exc_idle_stall", {31'b0, bus.stall_req}, 32'd0);

    // Timer interrupt with pipeline drain
    bus.mstatus_mie = 1'b1; bus.mie_mtie = 1'b1; bus.timer_irq = 1'b1;
    tick(2);
    chk("irq_sync_no_stall", {31'b0, bus.stall_req}, 32'd0);
    tick(1);
    chk("irq_drain_stall", {31'b0, bus.stall_req}, 32'd1);
    chk("irq_drain_state", {30'b0, bus.state_dbg}, 32'd1);
    tick(5);
    chk("irq_drain_hold", {30'b0, bus.state_dbg}, 32'd1);
    bus.pipe_empty = 1'b1; bus.next_pc = 32'h244;
    push_trap(32'h8000_0007, 32'h244, 32'h0, 32'h100);
    tick(1);
    bus.pipe_empty = 1'b0; bus.mstatus_mie = 1'b0;
    tick(3);
    chk("irq_masked_idle", {30'b0, bus.state_dbg}, 32'd0);
    bus.timer_irq = 1'b0;
    tick(4);

    // Exception, mret and interrupt in the same cycle
    bus.mstatus_mie = 1'b1; bus.timer_irq = 1'b1;
    tick(2);
    bus.exc_valid = 1'b1; bus.exc_cause = 4'd11; bus.exc_pc = 32'h400; bus.exc_tval = 32'h11;
    bus.mret_req = 1'b1; bus.mepc = 32'h777;
    push_trap(32'hB, 32'h400, 32'h11, 32'h100);
    tick(1);
    bus.exc_valid = 1'b0; bus.mret_req = 1'b0; bus.mstatus_mie = 1'b0;
    tick(3);
    chk("prio_idle", {30'b0, bus.state_dbg}, 32'd0);
    bus.timer_irq = 1'b0;
    tick(4);

    // mret, with an exception pulsed during RECOVER
    bus.mepc = 32'h300; bus.mret_req = 1'b1;
    push_mret(32'h300);
    tick(1);
    bus.mret_req = 1'b0; bus.mepc = 32'h999;
    tick(1);
    chk("mret_recover_state", {30'b0, bus.state_dbg}, 32'd3);
    bus.exc_valid = 1'b1; bus.exc_cause = 4'd5;
    tick(1);
    bus.exc_valid = 1'b0;
    chk("mret_shadow_ignored", {30'b0, bus.state_dbg}, 32'd0);
    tick(2);

    // Drain abandoned when MTIE clears, then U-mode interrupt with MIE=0
    bus.mstatus_mie = 1'b1; bus.mie_mtie = 1'b1; bus.timer_irq = 1'b1;
    tick(3);
    chk("abort_drain_state", {30'b0, bus.state_dbg}, 32'd1);
    tick(2);
    bus.mie_mtie = 1'b0;
    tick(1);
    chk("abort_idle_state", {30'b0, bus.state_dbg}, 32'd0);
    chk("abort_stall_drop", {31'b0, bus.stall_req}, 32'd0);
    bus.priv_mode = 2'b00; bus.mstatus_mie = 1'b0; bus.mie_mtie = 1'b1;
    tick(1);
    chk("umode_drain_state", {30'b0, bus.state_dbg}, 32'd1);
    chk("umode_drain_stall", {31'b0, bus.stall_req}, 32'd1);
    bus.pipe_empty = 1'b1; bus.next_pc = 32'h500;
    push_trap(32'h8000_0007, 32'h500, 32'h0, 32'h100);
    tick(1);
    bus.pipe_empty = 1'b0; bus.mie_mtie = 1'b0; bus.timer_irq = 1'b0;
    tick(4);
    chk("umode_idle", {30'b0, bus.state_dbg}, 32'd0);

    // Asynchronous reset while draining
    bus.priv_mode = 2'b11; bus.mstatus_mie = 1'b1; bus.mie_mtie = 1'b1; bus.timer_irq = 1'b1;
    tick(3);
    chk("rst_mid_pre_state", {30'b0, bus.state_dbg}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_state", {30'b0, bus.state_dbg}, 32'd0);
    chk("rst_mid_stall", {31'b0, bus.stall_req}, 32'd0);
    chk("rst_mid_cause", bus.trap_cause, 32'd0);
    chk("rst_mid_redirect_pc", bus.redirect_pc, 32'd0);
    bus.timer_irq = 1'b0; bus.mie_mtie = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(4);
    chk("post_rst_idle", {30'b0, bus.state_dbg}, 32'd0);

    chk("pending_expectations", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
